// File: rtl/trace_player.sv
// Trace sequencer: walks the trace ROM, issues each reference to the cache model
// one at a time over valid/ready, and gathers saturating access/hit/miss statistics.
module trace_player #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TRACE_LEN = 6,
  parameter int CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_trace_addr,
  input  logic [DATA_W-1:0] i_trace_ref,
  output logic              o_req_valid,
  output logic [DATA_W-1:0] o_req_addr,
  input  logic              i_req_ready,
  input  logic              i_resp_valid,
  input  logic              i_resp_hit,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_access_count,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam bit               EMPTY_TRACE = (TRACE_LEN == 0);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(EMPTY_TRACE ? 0 : TRACE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_req_addr;
  logic              r_req_valid;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_access_count;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  // The ROM index is held in idx for the whole run; the ROM answers combinationally.
  assign o_trace_addr   = r_idx;
  assign o_req_addr     = r_req_addr;
  assign o_req_valid    = r_req_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_access_count = r_access_count;
  assign o_hit_count    = r_hit_count;
  assign o_miss_count   = r_miss_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_req_addr     <= '0;
      r_req_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_access_count <= '0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_idx          <= '0;
            r_access_count <= '0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
            if (EMPTY_TRACE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          r_req_addr  <= i_trace_ref;
          r_req_valid <= 1'b1;
          r_state     <= S_ISSUE;
        end

        S_ISSUE: begin
          // req_addr is only loaded in FETCH, so it stays put under backpressure.
          if (i_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_resp_valid) begin
            if (r_access_count != CNT_MAX) begin
              r_access_count <= r_access_count + 1'b1;
            end
            if (i_resp_hit) begin
              if (r_hit_count != CNT_MAX) begin
                r_hit_count <= r_hit_count + 1'b1;
              end
            end else begin
              if (r_miss_count != CNT_MAX) begin
                r_miss_count <= r_miss_count + 1'b1;
              end
            end
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_player.sv
// Directed bench for trace_player: main 6-entry instance, an empty-trace instance
// and a 2-bit-counter instance, each driven against a small in-bench cache model.
module tb_trace_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  // main instance: TRACE_LEN=6, CNT_W=16
  logic        start, req_ready, resp_valid, resp_hit;
  logic [15:0] trace_addr;
  logic [31:0] trace_ref, req_addr;
  logic        req_valid, busy, done;
  logic [15:0] access_count, hit_count, miss_count;

  // empty-trace instance
  logic        z_start;
  logic [15:0] z_trace_addr;
  logic [31:0] z_req_addr;
  logic        z_req_valid, z_busy, z_done;
  logic [15:0] z_access, z_hit, z_miss;

  // 2-bit counter instance
  logic        s_start, s_resp_valid;
  logic [15:0] s_trace_addr;
  logic [31:0] s_trace_ref, s_req_addr;
  logic        s_req_valid, s_busy, s_done;
  logic [1:0]  s_access, s_hit, s_miss;

  logic [31:0] exp_addr [6] = '{32'h0, 32'h0, 32'h5000_0000, 32'h5000_0000, 32'h5000_0000, 32'h0};

  function automatic logic [31:0] main_rom(input logic [15:0] a);
    case (a)
      16'd2, 16'd3, 16'd4: return 32'h5000_0000;
      default:             return 32'h0;
    endcase
  endfunction

  always_comb trace_ref   = main_rom(trace_addr);
  always_comb s_trace_ref = 32'h100 + {16'h0, s_trace_addr};

  trace_player #(.ADDR_W(16), .DATA_W(32), .TRACE_LEN(6), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_trace_addr(trace_addr),
    .i_trace_ref(trace_ref), .o_req_valid(req_valid), .o_req_addr(req_addr),
    .i_req_ready(req_ready), .i_resp_valid(resp_valid), .i_resp_hit(resp_hit),
    .o_busy(busy), .o_done(done), .o_access_count(access_count),
    .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  trace_player #(.ADDR_W(16), .DATA_W(32), .TRACE_LEN(0), .CNT_W(16)) u_zero (
    .i_clk(clk), .i_rst(rst), .i_start(z_start), .o_trace_addr(z_trace_addr),
    .i_trace_ref(32'h0), .o_req_valid(z_req_valid), .o_req_addr(z_req_addr),
    .i_req_ready(1'b1), .i_resp_valid(1'b0), .i_resp_hit(1'b0),
    .o_busy(z_busy), .o_done(z_done), .o_access_count(z_access),
    .o_hit_count(z_hit), .o_miss_count(z_miss)
  );

  trace_player #(.ADDR_W(16), .DATA_W(32), .TRACE_LEN(6), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .o_trace_addr(s_trace_addr),
    .i_trace_ref(s_trace_ref), .o_req_valid(s_req_valid), .o_req_addr(s_req_addr),
    .i_req_ready(1'b1), .i_resp_valid(s_resp_valid), .i_resp_hit(1'b0),
    .o_busy(s_busy), .o_done(s_done), .o_access_count(s_access),
    .o_hit_count(s_hit), .o_miss_count(s_miss)
  );

  // results of the last run_trace
  int          rn_cycles, rn_accepts, rn_issued, rn_stalled, rn_bad_hold, rn_bad_wait;
  logic [31:0] rn_addr [6];
  logic [15:0] rn_acc0;
  logic        rn_done0;

  // Drives one run of the main instance with a hit-iff-same-as-previous cache model.
  // Entry arguments select where to stall ready, delay the response, inject a
  // response during the ISSUE handshake, or pulse start while waiting (-1 = never).
  task automatic run_trace(input int stall_entry, input int stall_n, input int delay_entry,
                           input int delay_n, input int spur_entry, input int start_entry);
    int          entry, stall_left, wait_left, phase;
    logic [31:0] hold, prev;
    bit          prev_vld, seen;
    rn_cycles = 0; rn_accepts = 0; rn_issued = 0; rn_stalled = 0;
    rn_bad_hold = 0; rn_bad_wait = 0;
    entry = 0; phase = 0; stall_left = 0; wait_left = 0;
    prev_vld = 1'b0; seen = 1'b0; hold = 32'h0; prev = 32'h0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    rn_acc0 = access_count; rn_done0 = done;
    while (!done && rn_cycles < 300) begin
      req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0; start = 1'b0;
      if (phase == 0) begin
        if (req_valid) begin
          if (!seen) begin
            seen = 1'b1; hold = req_addr;
            if (rn_issued < 6) rn_addr[rn_issued] = req_addr;
            rn_issued++;
            stall_left = (entry == stall_entry) ? stall_n : 0;
          end
          if (req_addr !== hold) rn_bad_hold++;
          if (stall_left > 0) begin
            stall_left--; rn_stalled++;
          end else begin
            req_ready = 1'b1; rn_accepts++; phase = 1;
            wait_left = (entry == delay_entry) ? delay_n : 0;
            if (entry == spur_entry) begin resp_valid = 1'b1; resp_hit = 1'b1; end
          end
        end
      end else begin
        if (req_valid !== 1'b0) rn_bad_wait++;
        if (busy !== 1'b1) rn_bad_wait++;
        if (entry == start_entry) start = 1'b1;
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          resp_valid = 1'b1; resp_hit = prev_vld && (hold == prev);
          prev = hold; prev_vld = 1'b1;
          entry++; phase = 0; seen = 1'b0;
        end
      end
      @(negedge clk); rn_cycles++;
    end
    req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; start = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
    z_start = 1'b0; s_start = 1'b0; s_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!req_valid && n < 10) begin @(negedge clk); n++; end
    n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL reset_pre_issue req_valid got %0b want 1", req_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid got %0b want 0", req_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (req_addr !== 32'h0 || trace_addr !== 16'h0) begin n_errors++; $display("FAIL reset_addr got %0h/%0h want 0/0", req_addr, trace_addr); end
    n_checks++; if ({access_count, hit_count, miss_count} !== 48'h0) begin n_errors++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", access_count, hit_count, miss_count); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || req_valid !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_start_ignored busy/req_valid/done got %0b%0b%0b want 000", busy, req_valid, done); end
  endtask

  task automatic test_full_run;
    run_trace(-1, 0, -1, 0, -1, -1);
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (rn_addr[i] !== exp_addr[i]) begin n_errors++; $display("FAIL full_req_addr[%0d] got %0h want %0h", i, rn_addr[i], exp_addr[i]); end
    end
    n_checks++; if (done !== 1'b1 || rn_cycles != 18) begin n_errors++; $display("FAIL full_done_cycle got done=%0b at %0d want done=1 at 18", done, rn_cycles); end
    n_checks++; if (rn_issued != 6 || rn_accepts != 6) begin n_errors++; $display("FAIL full_requests got %0d/%0d want 6/6", rn_issued, rn_accepts); end
    n_checks++; if (access_count !== 16'd6 || hit_count !== 16'd3 || miss_count !== 16'd3) begin n_errors++; $display("FAIL full_counts got %0d/%0d/%0d want 6/3/3", access_count, hit_count, miss_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL full_busy_at_done got %0b want 0", busy); end
    n_checks++; if (rn_bad_wait != 0) begin n_errors++; $display("FAIL full_wait_protocol got %0d want 0", rn_bad_wait); end
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL full_done_held got %0b want 1", done); end
  endtask

  task automatic test_backpressure;
    run_trace(2, 5, -1, 0, -1, -1);
    n_checks++; if (rn_stalled != 5 || rn_bad_hold != 0) begin n_errors++; $display("FAIL bp_hold got stalled=%0d bad=%0d want 5/0", rn_stalled, rn_bad_hold); end
    n_checks++; if (rn_addr[2] !== 32'h5000_0000) begin n_errors++; $display("FAIL bp_addr got %0h want 50000000", rn_addr[2]); end
    n_checks++; if (rn_accepts != 6 || rn_issued != 6) begin n_errors++; $display("FAIL bp_accepts got %0d/%0d want 6/6", rn_accepts, rn_issued); end
    n_checks++; if (done !== 1'b1 || rn_cycles != 23) begin n_errors++; $display("FAIL bp_done_cycle got done=%0b at %0d want done=1 at 23", done, rn_cycles); end
    n_checks++; if (access_count !== 16'd6 || hit_count !== 16'd3 || miss_count !== 16'd3) begin n_errors++; $display("FAIL bp_counts got %0d/%0d/%0d want 6/3/3", access_count, hit_count, miss_count); end
  endtask

  task automatic test_spurious_late;
    @(negedge clk); resp_valid = 1'b1; resp_hit = 1'b1;
    @(negedge clk); resp_valid = 1'b0; resp_hit = 1'b0;
    n_checks++; if (access_count !== 16'd6 || hit_count !== 16'd3) begin n_errors++; $display("FAIL spur_done_counts got %0d/%0d want 6/3", access_count, hit_count); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); resp_valid = 1'b1; resp_hit = 1'b1;
    repeat (2) @(negedge clk);
    resp_valid = 1'b0; resp_hit = 1'b0;
    n_checks++; if (access_count !== 16'd0 || hit_count !== 16'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL spur_idle got acc=%0d hit=%0d busy=%0b want 0/0/0", access_count, hit_count, busy); end
    run_trace(-1, 0, 3, 10, 0, -1);
    n_checks++; if (access_count !== 16'd6 || hit_count !== 16'd3 || miss_count !== 16'd3) begin n_errors++; $display("FAIL spur_issue_counts got %0d/%0d/%0d want 6/3/3", access_count, hit_count, miss_count); end
    n_checks++; if (rn_bad_wait != 0 || rn_issued != 6) begin n_errors++; $display("FAIL late_wait got bad=%0d issued=%0d want 0/6", rn_bad_wait, rn_issued); end
    n_checks++; if (done !== 1'b1 || rn_cycles != 28) begin n_errors++; $display("FAIL late_done_cycle got done=%0b at %0d want done=1 at 28", done, rn_cycles); end
  endtask

  task automatic test_restart;
    run_trace(-1, 0, -1, 0, -1, 1);
    n_checks++; if (rn_acc0 !== 16'd0 || rn_done0 !== 1'b0) begin n_errors++; $display("FAIL restart_clear got acc=%0d done=%0b want 0/0", rn_acc0, rn_done0); end
    n_checks++; if (done !== 1'b1 || rn_cycles != 18 || rn_issued != 6) begin n_errors++; $display("FAIL wait_start_ignored got done=%0b cyc=%0d req=%0d want 1/18/6", done, rn_cycles, rn_issued); end
    n_checks++; if (access_count !== 16'd6 || hit_count !== 16'd3 || miss_count !== 16'd3) begin n_errors++; $display("FAIL wait_start_counts got %0d/%0d/%0d want 6/3/3", access_count, hit_count, miss_count); end
    run_trace(-1, 0, -1, 0, -1, -1);
    n_checks++; if (rn_acc0 !== 16'd0 || rn_done0 !== 1'b0) begin n_errors++; $display("FAIL rerun_clear got acc=%0d done=%0b want 0/0", rn_acc0, rn_done0); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (rn_addr[i] !== exp_addr[i]) begin n_errors++; $display("FAIL rerun_req_addr[%0d] got %0h want %0h", i, rn_addr[i], exp_addr[i]); end
    end
    n_checks++; if (done !== 1'b1 || rn_cycles != 18 || hit_count !== 16'd3 || miss_count !== 16'd3) begin n_errors++; $display("FAIL rerun_result got done=%0b cyc=%0d hit=%0d miss=%0d want 1/18/3/3", done, rn_cycles, hit_count, miss_count); end
  endtask

  task automatic test_zero_len;
    int bad_req;
    n_checks++; if (z_done !== 1'b0) begin n_errors++; $display("FAIL zero_pre_done got %0b want 0", z_done); end
    @(negedge clk); z_start = 1'b1;
    @(negedge clk); z_start = 1'b0;
    n_checks++; if (z_done !== 1'b1 || z_busy !== 1'b0) begin n_errors++; $display("FAIL zero_done got done=%0b busy=%0b want 1/0", z_done, z_busy); end
    bad_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (z_req_valid !== 1'b0 || z_done !== 1'b1) bad_req++;
      @(negedge clk);
    end
    n_checks++; if (bad_req != 0 || z_access !== 16'd0 || z_trace_addr !== 16'd0) begin n_errors++; $display("FAIL zero_no_req got bad=%0d acc=%0d addr=%0d want 0/0/0", bad_req, z_access, z_trace_addr); end
  endtask

  task automatic test_saturate;
    int  n;
    bit  accepted;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    accepted = 1'b0; n = 0;
    while (!s_done && n < 100) begin
      s_resp_valid = accepted;
      accepted = s_req_valid;
      @(negedge clk); n++;
    end
    s_resp_valid = 1'b0;
    n_checks++; if (s_done !== 1'b1) begin n_errors++; $display("FAIL sat_done got %0b want 1 after %0d cycles", s_done, n); end
    n_checks++; if (s_miss !== 2'd3 || s_hit !== 2'd0 || s_access !== 2'd3) begin n_errors++; $display("FAIL sat_counts got acc=%0d hit=%0d miss=%0d want 3/0/3", s_access, s_hit, s_miss); end
    n_checks++; if (s_trace_addr !== 16'd5 || s_req_addr !== 32'h105) begin n_errors++; $display("FAIL sat_last_idx got idx=%0d addr=%0h want 5/105", s_trace_addr, s_req_addr); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_spurious_late();
    test_restart();
    test_zero_len();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_player.md
Name: trace_player

Overview:
- Sequencer that sits directly downstream of the trace ROM and upstream of the cache model.
- Steps the ROM index from 0 to TRACE_LEN-1 and registers each 32-bit reference.
- Issues each reference to the cache over a valid/ready request channel, then waits for the hit/miss response.
- Accumulates access, hit and miss statistics and flags completion of the trace run.

Parameters:
- ADDR_W, 16, ROM index width (matches the trace ROM address).
- DATA_W, 32, reference width.
- TRACE_LEN, 6, number of valid trace entries (legal range 0 to 2^ADDR_W).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a trace run.
- trace_addr  out  ADDR_W  index driven to the trace ROM.
- trace_ref  in  DATA_W  reference returned combinationally by the ROM.
- req_valid  out  1  request to the cache is valid.
- req_addr  out  DATA_W  reference address issued to the cache.
- req_ready  in  1  cache accepts the request.
- resp_valid  in  1  cache response strobe.
- resp_hit  in  1  1 = hit, 0 = miss; qualified by resp_valid.
- busy  out  1  a run is in progress.
- done  out  1  run complete; held until the next start or reset.
- access_count  out  CNT_W  responses received.
- hit_count  out  CNT_W  hits.
- miss_count  out  CNT_W  misses.

Behaviour:
- Reset state: asynchronous rst forces state IDLE; idx, trace_addr, req_addr, all counters = 0; req_valid, busy, done = 0. Reset asserted mid-run aborts the run immediately with no further requests.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE or DONE, start=1:
  - Clear all counters, set idx=0, clear done.
  - Go to FETCH, or directly to DONE with done=1 if TRACE_LEN==0.
  - start in any other state is ignored.
- FETCH (1 cycle):
  - trace_addr = idx.
  - At the clock edge: req_addr <= trace_ref, go to ISSUE.
  - The ROM is combinational, so no extra wait cycle is needed.
- ISSUE:
  - req_valid = 1; req_addr held stable while req_valid=1 and req_ready=0.
  - On req_valid && req_ready: go to WAIT; req_valid drops on the next cycle.
- WAIT:
  - Wait for resp_valid, with no timeout.
  - On resp_valid: access_count += 1; hit_count += 1 if resp_hit=1, else miss_count += 1.
  - Then, if idx == TRACE_LEN-1, go to DONE; otherwise idx += 1 and go to FETCH.
- resp_valid outside WAIT, including the cycle of the ISSUE handshake, is ignored. The cache must respond no earlier than one cycle after acceptance.
- Counters saturate at 2^CNT_W-1 and never wrap. access_count == hit_count + miss_count whenever no counter has saturated.
- busy = 1 in FETCH, ISSUE and WAIT. done = 1 in DONE only.
- idx never exceeds TRACE_LEN-1, so no out-of-range ROM index is ever driven during a run.
- Minimum throughput: 3 cycles per reference (FETCH, ISSUE, WAIT) with req_ready=1 and a 1-cycle response.
- Latency: start sampled at edge 0 gives req_valid=1 in cycle 2 with req_addr equal to ROM entry 0.
- Only one outstanding request at a time.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle → all outputs 0 and state IDLE without a clock edge; start pulses before reset release are ignored.
- Full run: ROM = {0, 0, 0x50000000, 0x50000000, 0x50000000, 0}, req_ready tied 1, cache model reports hit iff address equals the previous address. Required: req_addr sequence 0, 0, 0x50000000, 0x50000000, 0x50000000, 0; hit_count=3, miss_count=3, access_count=6; done=1 exactly 18 cycles after start.
- Backpressure: req_ready held 0 for 5 cycles on entry 2 → req_valid stays 1 and req_addr stays 0x50000000 for all 5 cycles; exactly one acceptance; final counters unchanged from the full-run case.
- Spurious/late responses:
  - resp_valid pulsed in IDLE and during ISSUE → no counter change.
  - Response delayed 10 cycles in WAIT → busy stays 1, no new request is issued.
- Restart and ignored start:
  - start pulsed during WAIT → ignored.
  - start after DONE → counters clear to 0, done drops, run repeats with identical results.
- Edge cases:
  - TRACE_LEN=0 → done=1 one cycle after start with no req_valid.
  - CNT_W=2 with the 6-entry all-miss trace → miss_count saturates at 3.
